// File: rtl/cordic_pkg.sv
// Shared constants, types and the arctangent table for the CORDIC vectoring engine.
// All angles and magnitudes are Q4.23; the internal x/y datapath widens to Q6.23.
package cordic_pkg;

  localparam int unsigned W      = 27;  // external word width
  localparam int unsigned F      = 23;  // fraction bits
  localparam int unsigned Q      = W - F;
  localparam int unsigned IW     = 29;  // internal x/y width
  localparam int unsigned ITER   = 20;
  localparam int unsigned PER_CY = 2;
  localparam int unsigned NCY    = ITER / PER_CY;
  localparam int unsigned CntW   = 4;

  typedef logic signed [W-1:0]  q_t;
  typedef logic signed [IW-1:0] iq_t;

  localparam q_t PI       = 27'sh1921FB5;
  localparam q_t PI_2     = PI >>> 1;
  localparam q_t CORDIC_K = 27'sh04DBA77;

  typedef enum logic [1:0] {StIdle, StBusy, StComp, StDone} state_e;

  // atan(2^-i) in Q4.23; beyond i=9 the angle equals 2^-i to well under one LSB.
  function automatic q_t atan_lut(input logic [4:0] i);
    q_t a;
    unique case (i)
      5'd0:    a = 27'sh06487ED;
      5'd1:    a = 27'sh03B58CE;
      5'd2:    a = 27'sh01F5B76;
      5'd3:    a = 27'sh00FEADD;
      5'd4:    a = 27'sh007FD57;
      5'd5:    a = 27'sh003FFAB;
      5'd6:    a = 27'sh001FFF5;
      5'd7:    a = 27'sh000FFFF;
      5'd8:    a = 27'sh0008000;
      5'd9:    a = 27'sh0004000;
      5'd10:   a = 27'sh0002000;
      5'd11:   a = 27'sh0001000;
      5'd12:   a = 27'sh0000800;
      5'd13:   a = 27'sh0000400;
      5'd14:   a = 27'sh0000200;
      5'd15:   a = 27'sh0000100;
      5'd16:   a = 27'sh0000080;
      5'd17:   a = 27'sh0000040;
      5'd18:   a = 27'sh0000020;
      5'd19:   a = 27'sh0000010;
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_vec_chain.sv
// Combinational chain of PerCy vectoring micro-rotations starting at stage base_i.
// Each stage drives y toward zero and accumulates the rotated angle in z.
module cordic_vec_chain
  import cordic_pkg::*;
#(
  parameter int unsigned PerCy = PER_CY
) (
  input  logic signed [IW-1:0] x_i,
  input  logic signed [IW-1:0] y_i,
  input  logic signed [W-1:0]  z_i,
  input  logic        [4:0]    base_i,
  output logic signed [IW-1:0] x_o,
  output logic signed [IW-1:0] y_o,
  output logic signed [W-1:0]  z_o
);

  logic signed [IW-1:0] x, y;
  logic signed [W-1:0]  z;
  logic        [4:0]    idx;

  always_comb begin
    x   = x_i;
    y   = y_i;
    z   = z_i;
    idx = base_i;
    for (int k = 0; k < int'(PerCy); k++) begin
      idx = base_i + 5'(k);
      // Both updates must see the pre-update x and y.
      if (!y[IW-1]) begin
        {x, y} = {x + (y >>> idx), y - (x >>> idx)};
        z      = z + atan_lut(idx);
      end else begin
        {x, y} = {x - (y >>> idx), y + (x >>> idx)};
        z      = z - atan_lut(idx);
      end
    end
    x_o = x;
    y_o = y;
    z_o = z;
  end

endmodule

// File: rtl/cordic_vector.sv
// Iterative CORDIC vectoring engine: (x, y) -> (atan2(y, x), |(x, y)|) in Q4.23.
// Holds the handshake FSM, quadrant pre-rotation, zero-input flag and gain compensation.
module cordic_vector
  import cordic_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                start,
  input  logic signed [W-1:0] x_i,
  input  logic signed [W-1:0] y_i,
  output logic signed [W-1:0] angle_o,
  output logic signed [W-1:0] mag_o,
  output logic                busy,
  output logic                done
);

  localparam logic signed [IW+W-1:0] MagMax = (IW+W)'(27'h3FFFFFF);

  state_e               state_q, state_d;
  logic    [CntW-1:0]   cnt_q, cnt_d;
  logic signed [IW-1:0] x_q, x_d, y_q, y_d;
  logic signed [W-1:0]  z_q, z_d;
  logic signed [W-1:0]  angle_q, angle_d, mag_q, mag_d;
  logic                 done_q, done_d;
  logic                 zero_q, zero_d;

  logic signed [IW-1:0] xe, ye, cx, cy;
  logic signed [W-1:0]  cz, mag_sat;
  logic        [4:0]    base;
  logic signed [IW+W-1:0] prod, prod_sh;

  assign xe   = {{(IW-W){x_i[W-1]}}, x_i};
  assign ye   = {{(IW-W){y_i[W-1]}}, y_i};
  assign base = 5'(cnt_q) * 5'(PER_CY);

  cordic_vec_chain #(
    .PerCy(PER_CY)
  ) u_chain (
    .x_i   (x_q),
    .y_i   (y_q),
    .z_i   (z_q),
    .base_i(base),
    .x_o   (cx),
    .y_o   (cy),
    .z_o   (cz)
  );

  assign prod    = x_q * CORDIC_K;
  assign prod_sh = prod >>> F;

  always_comb begin
    mag_sat = prod_sh[W-1:0];
    if (prod_sh > MagMax) begin
      mag_sat = 27'h3FFFFFF;
    end else if (prod_sh[IW+W-1]) begin
      mag_sat = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    done_d  = done_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        done_d = 1'b0;
        if (start) begin
          cnt_d   = '0;
          zero_d  = (x_i == '0) && (y_i == '0);
          state_d = StBusy;
          // Fold the left half-plane into the right so the chain converges.
          if (!xe[IW-1]) begin
            x_d = xe;
            y_d = ye;
            z_d = '0;
          end else if (!ye[IW-1]) begin
            x_d = ye;
            y_d = -xe;
            z_d = PI_2;
          end else begin
            x_d = -ye;
            y_d = xe;
            z_d = -PI_2;
          end
        end
      end
      StBusy: begin
        x_d   = cx;
        y_d   = cy;
        z_d   = cz;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(NCY - 1)) begin
          state_d = StComp;
        end
      end
      StComp: begin
        angle_d = zero_q ? '0 : z_q;
        mag_d   = zero_q ? '0 : mag_sat;
        done_d  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      angle_q <= '0;
      mag_q   <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  assign angle_o = angle_q;
  assign mag_o   = mag_q;
  assign done    = done_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_cordic_vector.sv
// Directed bench for cordic_vector: hand-computed polar results, latency, stalls,
// held start and asynchronous reset abort.
module tb_cordic_vector;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clk_en;
  logic               start;
  logic signed [26:0] x_i, y_i;
  logic signed [26:0] angle_o, mag_o;
  logic               busy, done;

  int total = 0;
  int bad   = 0;

  localparam int ATol = 64;
  localparam int MTol = 72;

  cordic_vector u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .start  (start),
    .x_i    (x_i),
    .y_i    (y_i),
    .angle_o(angle_o),
    .mag_o  (mag_o),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp, input int tol);
    int d;
    total++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) tol %0d", tag, got, got, exp, exp, tol);
    end
  endtask

  // Launch one operation; lat counts enabled edges after the accepting edge up to done.
  task automatic op(input int x, input int y, input bit stall, output int lat);
    @(negedge clk);
    x_i    = 27'(x);
    y_i    = 27'(y);
    start  = 1'b1;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1, 0);
    lat = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (stall) clk_en = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      if (clk_en) lat++;
      #1;
    end
    clk_en = 1'b1;
    chk("done_seen", int'(done), 1, 0);
    @(posedge clk);
    #1;
    chk("done_falls", int'(done), 0, 0);
  endtask

  typedef struct {
    int x;
    int y;
    int ang;
    int mag;
    int atol;
    int mtol;
  } vec_t;

  vec_t vecs[$];
  int   lat;
  int   pulses, hi;
  logic prev;

  initial begin
    rst_n  = 1'b0;
    clk_en = 1'b1;
    start  = 1'b0;
    x_i    = '0;
    y_i    = '0;
    #12;
    chk("rst_angle", int'(angle_o), 0, 0);
    chk("rst_mag", int'(mag_o), 0, 0);
    chk("rst_done", int'(done), 0, 0);
    chk("rst_busy", int'(busy), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{32'h0800000, 0, 0, 32'h0800000, ATol, MTol});
    vecs.push_back('{32'h0800000, 32'h0800000, 32'h06487ED, 32'h0B504F3, ATol, MTol});
    vecs.push_back('{-32'h0800000, 0, 32'h1921FB5, 32'h0800000, ATol, MTol});
    vecs.push_back('{0, -32'h0800000, -32'h0C90FDA, 32'h0800000, ATol, MTol});
    vecs.push_back('{0, 0, 0, 0, 0, 0});
    vecs.push_back('{-32'h2000000, -32'h2000000, -32'h12D97C8, 32'h2D413CD, ATol, MTol});
    vecs.push_back('{32'h2000000, -32'h2000000, -32'h06487ED, 32'h2D413CD, ATol, MTol});
    vecs.push_back('{-32'h0800000, 32'h0800000, 32'h12D97C8, 32'h0B504F3, ATol, MTol});

    foreach (vecs[i]) begin
      op(vecs[i].x, vecs[i].y, 1'b0, lat);
      chk($sformatf("lat_%0d", i), lat, 11, 0);
      chk($sformatf("angle_%0d", i), int'(angle_o), vecs[i].ang, vecs[i].atol);
      chk($sformatf("mag_%0d", i), int'(mag_o), vecs[i].mag, vecs[i].mtol);
    end

    // Random clk_en stalls must not change the result or the enabled-edge latency.
    for (int r = 0; r < 2; r++) begin
      op(32'h0800000, 32'h0800000, 1'b1, lat);
      chk("stall_lat", lat, 11, 0);
      chk("stall_angle", int'(angle_o), 32'h06487ED, ATol);
      chk("stall_mag", int'(mag_o), 32'h0B504F3, MTol);
    end

    // Start held high: accepts at E0 and E13 only, one-cycle done for each.
    @(negedge clk);
    x_i    = 27'h0800000;
    y_i    = '0;
    start  = 1'b1;
    pulses = 0;
    hi     = 0;
    prev   = 1'b0;
    for (int n = 0; n < 26; n++) begin
      @(posedge clk);
      #1;
      if (done) hi++;
      if (done && !prev) pulses++;
      prev = done;
    end
    start = 1'b0;
    chk("held_pulses", pulses, 2, 0);
    chk("held_hi_cycles", hi, 2, 0);
    chk("held_angle", int'(angle_o), 0, ATol);
    chk("held_mag", int'(mag_o), 32'h0800000, MTol);
    chk("held_idle", int'(busy), 0, 0);

    // Asynchronous reset mid-BUSY clears outputs without a clock edge.
    @(negedge clk);
    x_i   = 27'h0800000;
    y_i   = 27'h0800000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_angle", int'(angle_o), 0, 0);
    chk("abort_mag", int'(mag_o), 0, 0);
    chk("abort_busy", int'(busy), 0, 0);
    chk("abort_done", int'(done), 0, 0);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0, 0);

    op(-32'h2000000, -32'h2000000, 1'b0, lat);
    chk("post_rst_lat", lat, 11, 0);
    chk("post_rst_angle", int'(angle_o), -32'h12D97C8, ATol);
    chk("post_rst_mag", int'(mag_o), 32'h2D413CD, MTol);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
